// File: rtl/mac_unit_pragmatic_seq_pkg.sv
// Shared width helpers and control typedefs for the pipelined Pragmatic MAC.
package mac_unit_pragmatic_seq_pkg;

   // A lane term is the activation widened by one sign bit, then shifted by
   // at most 2^SHIFT_WIDTH-1 positions.
   function automatic int lane_w(input int data_w, input int shift_w);
      return data_w + (1 << shift_w);
   endfunction

   // Each adder-tree level grows the operand by one bit.
   function automatic int tree_w(input int lane_width, input int vec_len);
      return lane_width + $clog2(vec_len);
   endfunction

   // Per-dot-product mode, captured from the first term only.
   typedef struct packed {
      logic load_accum;
      logic is_pooling;
   } mode_t;

endpackage

// File: rtl/mac_unit_pragmatic_seq_if.sv
// Term-input and result-output bundle of the Pragmatic MAC.
interface mac_unit_pragmatic_seq_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int VEC_LENGTH   = 16,
   parameter int SHIFT_WIDTH  = 3,
   parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
   parameter int CNT_WIDTH    = 8
);
   logic                                   in_valid;
   logic                                   in_ready;
   logic                                   in_last;
   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_in;
   logic [VEC_LENGTH-1:0][SHIFT_WIDTH-1:0] w_idx;
   logic [VEC_LENGTH-1:0]                  w_en;
   logic [VEC_LENGTH-1:0]                  is_neg;
   logic                                   load_accum;
   logic                                   is_pooling;
   logic [RESULT_WIDTH-1:0]                result_prev;
   logic                                   out_valid;
   logic                                   out_ready;
   logic [RESULT_WIDTH-1:0]                result;
   logic [CNT_WIDTH-1:0]                   term_cnt;

   // Producer of terms and consumer of results.
   modport master (
      output in_valid, in_last, act_in, w_idx, w_en, is_neg,
             load_accum, is_pooling, result_prev, out_ready,
      input  in_ready, out_valid, result, term_cnt
   );

   // The MAC itself.
   modport slave (
      input  in_valid, in_last, act_in, w_idx, w_en, is_neg,
             load_accum, is_pooling, result_prev, out_ready,
      output in_ready, out_valid, result, term_cnt
   );
endinterface

// File: rtl/mac_unit_pragmatic_seq_lane.sv
// One Pragmatic lane: optional negate, shift by the essential-bit index, gate.
module mac_unit_pragmatic_seq_lane
   import mac_unit_pragmatic_seq_pkg::*;
#(
   parameter  int DATA_WIDTH  = 8,
   parameter  int SHIFT_WIDTH = 3,
   localparam int LANE_W      = lane_w(DATA_WIDTH, SHIFT_WIDTH)
) (
   input  logic signed [DATA_WIDTH-1:0]  act_i,
   input  logic        [SHIFT_WIDTH-1:0] shift_i,
   input  logic                          en_i,
   input  logic                          neg_i,
   output logic signed [LANE_W-1:0]      term_o
);

   logic signed [DATA_WIDTH:0] act_wide;
   logic signed [DATA_WIDTH:0] act_sgn;
   logic signed [LANE_W-1:0]   act_ext;

   // Widen before negating so the most negative activation flips exactly.
   always_comb begin
      act_wide = {act_i[DATA_WIDTH-1], act_i};
      act_sgn  = neg_i ? -act_wide : act_wide;
      act_ext  = {{(LANE_W-DATA_WIDTH-1){act_sgn[DATA_WIDTH]}}, act_sgn};
      term_o   = en_i ? (act_ext << shift_i) : '0;
   end

endmodule

// File: rtl/mac_unit_pragmatic_seq.sv
// Pipelined Pragmatic MAC: lanes + adder tree (S1), accumulate (S2), result
// register with optional max-pooling, valid/ready on both sides.
module mac_unit_pragmatic_seq
   import mac_unit_pragmatic_seq_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int VEC_LENGTH   = 16,
   parameter int SHIFT_WIDTH  = 3,
   parameter int ACC_WIDTH    = DATA_WIDTH + 16,
   parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
   parameter int CNT_WIDTH    = 8
) (
   input logic                     clk,
   input logic                     reset,
   mac_unit_pragmatic_seq_if.slave bus
);

   localparam int LANE_W = lane_w(DATA_WIDTH, SHIFT_WIDTH);
   localparam int TREE_W = tree_w(LANE_W, VEC_LENGTH);
   localparam int LEVELS = $clog2(VEC_LENGTH);
   localparam int PAD_W  = ACC_WIDTH - RESULT_WIDTH;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   function automatic logic signed [RESULT_WIDTH-1:0] signed_max(
      input logic signed [RESULT_WIDTH-1:0] a,
      input logic signed [RESULT_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic signed [LANE_W-1:0] lane_term [VEC_LENGTH];
   logic signed [TREE_W-1:0] tree_sum;

   for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_lane
      mac_unit_pragmatic_seq_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .SHIFT_WIDTH(SHIFT_WIDTH)
      ) u_lane (
         .act_i  (bus.act_in[i]),
         .shift_i(bus.w_idx[i]),
         .en_i   (bus.w_en[i]),
         .neg_i  (bus.is_neg[i]),
         .term_o (lane_term[i])
      );
   end

   // Adder tree: level lv holds VEC_LENGTH>>lv nodes, one bit wider per level.
   for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
      logic signed [LANE_W+lv-1:0] node [VEC_LENGTH >> lv];
      if (lv == 0) begin : g_leaf
         for (genvar n = 0; n < VEC_LENGTH; n++) begin : g_n
            assign node[n] = lane_term[n];
         end
      end else begin : g_add
         for (genvar n = 0; n < (VEC_LENGTH >> lv); n++) begin : g_n
            assign node[n] =
               {g_lvl[lv-1].node[2*n][LANE_W+lv-2],   g_lvl[lv-1].node[2*n]} +
               {g_lvl[lv-1].node[2*n+1][LANE_W+lv-2], g_lvl[lv-1].node[2*n+1]};
         end
      end
   end

   assign tree_sum = g_lvl[LEVELS].node[0];

   logic adv;
   logic accept;

   // S1 state
   logic signed [TREE_W-1:0]       psum_q;
   logic                           v1_q;
   logic                           l1_q;
   logic                           f1_q;
   logic                           first_q;
   mode_t                          mode_q;
   logic signed [RESULT_WIDTH-1:0] rprev_q;

   // S2 / output state
   logic signed [ACC_WIDTH-1:0]    acc_q;
   logic        [CNT_WIDTH-1:0]    cnt_q;
   logic                           out_valid_q;
   logic signed [RESULT_WIDTH-1:0] result_q;
   logic        [CNT_WIDTH-1:0]    term_cnt_q;

   logic signed [ACC_WIDTH-1:0]    base;
   logic signed [ACC_WIDTH-1:0]    psum_ext;
   logic signed [ACC_WIDTH-1:0]    acc_d;
   logic        [CNT_WIDTH-1:0]    cnt_d;
   logic signed [RESULT_WIDTH-1:0] acc_top;
   logic signed [RESULT_WIDTH-1:0] result_d;

   assign adv    = !(out_valid_q && !bus.out_ready);
   assign accept = bus.in_valid && adv;

   // ---- S1: register the tree sum and the term's framing bits ----
   // Capture a term on acceptance; the first term of a product also latches the mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         psum_q  <= '0;
         v1_q    <= 1'b0;
         l1_q    <= 1'b0;
         f1_q    <= 1'b0;
         first_q <= 1'b1;
         mode_q  <= '0;
         rprev_q <= '0;
      end else if (adv) begin
         v1_q <= accept;
         if (accept) begin
            psum_q  <= tree_sum;
            l1_q    <= bus.in_last;
            f1_q    <= first_q;
            first_q <= bus.in_last;
            if (first_q) begin
               mode_q.load_accum <= bus.load_accum;
               mode_q.is_pooling <= bus.is_pooling;
               rprev_q           <= bus.result_prev;
            end
         end
      end
   end

   // Next accumulator, term count and candidate result for the term in S1.
   always_comb begin
      base     = mode_q.load_accum ? {rprev_q, {PAD_W{1'b0}}} : '0;
      psum_ext = {{(ACC_WIDTH-TREE_W){psum_q[TREE_W-1]}}, psum_q};
      acc_d    = (f1_q ? base : acc_q) + psum_ext;
      cnt_d    = f1_q ? CNT_WIDTH'(1) : sat_inc(cnt_q);
      acc_top  = acc_d[ACC_WIDTH-1 -: RESULT_WIDTH];
      result_d = mode_q.is_pooling ? signed_max(acc_top, rprev_q) : acc_top;
   end

   // ---- S2: accumulate across terms (wraps, no saturation) ----
   // Fold the registered partial sum into the running accumulator.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (v1_q && adv) begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   // ---- Output register: loaded by a last term, cleared when consumed ----
   // Publish a finished dot product; hold everything while the consumer stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         term_cnt_q  <= '0;
      end else if (adv) begin
         out_valid_q <= v1_q && l1_q;
         if (v1_q && l1_q) begin
            result_q   <= result_d;
            term_cnt_q <= cnt_d;
         end
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.term_cnt  = term_cnt_q;

endmodule

// File: tb/tb_mac_unit_pragmatic_seq.sv
// Bench for the pipelined Pragmatic MAC: directed table, hand-written
// multi-cycle sequences and a randomized run against an arithmetic model.
module tb_mac_unit_pragmatic_seq;

   localparam int DW = 8;
   localparam int VL = 16;
   localparam int SW = 3;
   localparam int AW = 24;
   localparam int RW = 16;
   localparam int CW = 8;

   typedef logic [VL-1:0][DW-1:0] act_vec_t;
   typedef logic [VL-1:0][SW-1:0] idx_vec_t;

   typedef struct {
      int            act;
      int            idx;
      logic [VL-1:0] en;
      logic [VL-1:0] neg;
      logic          load;
      logic          pool;
      logic [RW-1:0] rprev;
      logic [RW-1:0] exp_res;
   } vec_t;

   typedef struct packed {
      logic [RW-1:0] res;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   rnd_ready = 1'b0;

   always #5 clk = ~clk;

   mac_unit_pragmatic_seq_if #(
      .DATA_WIDTH(DW), .VEC_LENGTH(VL), .SHIFT_WIDTH(SW),
      .RESULT_WIDTH(RW), .CNT_WIDTH(CW)
   ) bus ();

   mac_unit_pragmatic_seq #(
      .DATA_WIDTH(DW), .VEC_LENGTH(VL), .SHIFT_WIDTH(SW),
      .ACC_WIDTH(AW), .RESULT_WIDTH(RW), .CNT_WIDTH(CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Sum of one term vector using plain integer arithmetic.
   function automatic longint lane_sum(input act_vec_t a, input idx_vec_t ix,
                                       input logic [VL-1:0] en, input logic [VL-1:0] ng);
      longint s = 0;
      for (int i = 0; i < VL; i++) begin
         longint t = longint'($signed(a[i]));
         if (ng[i]) t = -t;
         t = t * (longint'(1) << ix[i]);
         if (en[i]) s += t;
      end
      return s;
   endfunction

   function automatic act_vec_t fill_act(input int v);
      act_vec_t r;
      for (int i = 0; i < VL; i++) r[i] = DW'(v);
      return r;
   endfunction

   function automatic idx_vec_t fill_idx(input int v);
      idx_vec_t r;
      for (int i = 0; i < VL; i++) r[i] = SW'(v);
      return r;
   endfunction

   // Scoreboard / reference model state
   exp_t          exp_q [$];
   exp_t          e;
   longint        m_sum = 0;
   int            m_cnt = 0;
   bit            m_first = 1'b1;
   bit            m_load = 1'b0;
   bit            m_pool = 1'b0;
   logic [RW-1:0] m_rp = '0;
   logic [AW-1:0] acc24;
   logic [RW-1:0] top;

   // Observe accepted terms and delivered results on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_first = 1'b1;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got result 0x%0h, no result expected", bus.result);
            end else begin
               e = exp_q.pop_front();
               chk("sb_result", longint'(bus.result), longint'(e.res));
               chk("sb_cnt", longint'(bus.term_cnt), longint'(e.cnt));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            if (m_first) begin
               m_load = bus.load_accum;
               m_pool = bus.is_pooling;
               m_rp   = bus.result_prev;
               m_sum  = m_load ? longint'($signed(m_rp)) * 256 : 0;
               m_cnt  = 0;
            end
            m_sum  += lane_sum(bus.act_in, bus.w_idx, bus.w_en, bus.is_neg);
            m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_first = bus.in_last;
            if (bus.in_last) begin
               acc24 = m_sum[AW-1:0];
               top   = acc24[AW-1 -: RW];
               if (m_pool && ($signed(m_rp) > $signed(top))) top = m_rp;
               exp_q.push_back('{res: top, cnt: CW'(m_cnt)});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Present one term (starting just after a rising edge) until it is taken.
   task automatic drive(input act_vec_t a, input idx_vec_t ix, input logic [VL-1:0] en,
                        input logic [VL-1:0] ng, input logic last, input logic ld,
                        input logic pl, input logic [RW-1:0] rp, output int tries);
      bit acc = 1'b0;
      bus.act_in      = a;
      bus.w_idx       = ix;
      bus.w_en        = en;
      bus.is_neg      = ng;
      bus.in_last     = last;
      bus.load_accum  = ld;
      bus.is_pooling  = pl;
      bus.result_prev = rp;
      bus.in_valid    = 1'b1;
      tries = 0;
      while (!acc && tries < 50) begin
         @(negedge clk);
         acc = bus.in_ready;
         tick();
         tries++;
      end
      bus.in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL drive_timeout: term not accepted within 50 cycles");
      end
   endtask

   task automatic wait_out(input logic [RW-1:0] er, input logic [CW-1:0] ec, input string nm);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < 30) begin
         @(negedge clk);
         got = bus.out_valid;
         n++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: out_valid not seen within 30 cycles", nm);
      end else begin
         chk({nm, "_result"}, longint'(bus.result), longint'(er));
         chk({nm, "_cnt"}, longint'(bus.term_cnt), longint'(ec));
      end
   endtask

   vec_t tbl [6];
   int   tries;

   initial begin
      tbl[0] = '{16,   0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0001};
      tbl[1] = '{-128, 7, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0040};
      tbl[2] = '{16,   0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0101};
      tbl[3] = '{16,   0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0200, 16'h0200};
      tbl[4] = '{16,   0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'hFFFB, 16'h0001};
      tbl[5] = '{16,   0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'hFFFF};

      bus.in_valid    = 1'b0;
      bus.in_last     = 1'b0;
      bus.act_in      = '0;
      bus.w_idx       = '0;
      bus.w_en        = '0;
      bus.is_neg      = '0;
      bus.load_accum  = 1'b0;
      bus.is_pooling  = 1'b0;
      bus.result_prev = '0;
      bus.out_ready   = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_result", longint'(bus.result), 0);
      chk("rst_term_cnt", longint'(bus.term_cnt), 0);
      chk("rst_in_ready", longint'(bus.in_ready), 1);
      tick();
      reset = 1'b0;
      tick();

      // Single-term products from the table, with latency check.
      for (int k = 0; k < 6; k++) begin
         drive(fill_act(tbl[k].act), fill_idx(tbl[k].idx), tbl[k].en, tbl[k].neg, 1'b1,
               tbl[k].load, tbl[k].pool, tbl[k].rprev, tries);
         @(negedge clk);
         chk($sformatf("vec%0d_lat_early", k), longint'(bus.out_valid), 0);
         @(negedge clk);
         chk($sformatf("vec%0d_lat", k), longint'(bus.out_valid), 1);
         chk($sformatf("vec%0d_result", k), longint'(bus.result), longint'(tbl[k].exp_res));
         chk($sformatf("vec%0d_cnt", k), longint'(bus.term_cnt), 1);
         tick();
      end

      // Three back-to-back terms, then a new product with no bubble.
      for (int k = 0; k < 3; k++) begin
         drive(fill_act(127), fill_idx((k == 0) ? 7 : (k == 1) ? 4 : 0), '1, '0,
               k == 2, 1'b0, 1'b0, '0, tries);
         chk($sformatf("b2b_term%0d_tries", k), tries, 1);
      end
      drive(fill_act(16), fill_idx(0), '1, '0, 1'b1, 1'b0, 1'b0, '0, tries);
      chk("b2b_nobubble_tries", tries, 1);
      wait_out(16'd1150, 8'd3, "b2b_first");
      wait_out(16'h0001, 8'd1, "b2b_second");
      tick();

      // Backpressure: result held, input stalled.
      bus.out_ready = 1'b0;
      drive(fill_act(16), fill_idx(0), '1, '0, 1'b1, 1'b0, 1'b0, '0, tries);
      wait_out(16'h0001, 8'd1, "bp_a");
      tick();
      bus.act_in      = fill_act(16);
      bus.w_idx       = fill_idx(0);
      bus.w_en        = '1;
      bus.is_neg      = '0;
      bus.in_last     = 1'b1;
      bus.load_accum  = 1'b1;
      bus.is_pooling  = 1'b0;
      bus.result_prev = 16'h0100;
      bus.in_valid    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready", longint'(bus.in_ready), 0);
         chk("bp_out_valid", longint'(bus.out_valid), 1);
         chk("bp_result_hold", longint'(bus.result), 1);
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", longint'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_consumed", longint'(bus.out_valid), 0);
      wait_out(16'h0101, 8'd1, "bp_b");
      tick();

      // Reset in the middle of a product.
      for (int k = 0; k < 2; k++)
         drive(fill_act(16), fill_idx(0), '1, '0, 1'b0, 1'b0, 1'b0, '0, tries);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", longint'(bus.out_valid), 0);
      chk("midrst_term_cnt", longint'(bus.term_cnt), 0);
      chk("midrst_result", longint'(bus.result), 0);
      tick();
      drive(fill_act(16), fill_idx(0), '1, '0, 1'b1, 1'b0, 1'b0, '0, tries);
      wait_out(16'h0001, 8'd1, "after_rst");
      tick();

      // Term counter saturation: 260 terms of +1 on lane 0.
      for (int k = 0; k < 260; k++)
         drive(fill_act(1), fill_idx(0), 16'h0001, '0, k == 259, 1'b0, 1'b0, '0, tries);
      wait_out(16'h0001, 8'd255, "cnt_sat");
      tick();

      // Randomized products with gaps and random consumer stalls.
      rnd_ready = 1'b1;
      for (int p = 0; p < 40; p++) begin
         int nterms = $urandom_range(1, 6);
         for (int t = 0; t < nterms; t++) begin
            act_vec_t      a;
            idx_vec_t      ix;
            logic [VL-1:0] en;
            logic [VL-1:0] ng;
            for (int i = 0; i < VL; i++) begin
               a[i]  = DW'($urandom);
               ix[i] = SW'($urandom);
            end
            en = VL'($urandom);
            ng = VL'($urandom);
            drive(a, ix, en, ng, t == nterms - 1, 1'($urandom), 1'($urandom),
                  RW'($urandom), tries);
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      rnd_ready = 1'b0;
      bus.out_ready = 1'b1;
      repeat (20) tick();
      chk("sb_drain", longint'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_unit_pragmatic_seq.md
Name: mac_unit_pragmatic_seq

Overview:
Parametrised, pipelined successor to the 16-lane Pragmatic MAC.
- Per cycle, accepts one "essential-bit term" per lane: activation, shift index, sign and enable.
- Each term is signed, shifted and reduced through a generic log2(VEC_LENGTH) adder tree, then accumulated across terms until a last-marked term arrives.
- Emits one result per dot product over a valid/ready handshake, with optional max-pooling against result_prev.
- Sits between the PE-array weight-index decoder and the output/pooling buffer.

Parameters:
DATA_WIDTH, 8, activation width (signed)
VEC_LENGTH, 16, lanes; power of 2, >= 2
SHIFT_WIDTH, 3, shift-index width; max shift = 2^SHIFT_WIDTH-1
ACC_WIDTH, DATA_WIDTH+16, accumulator width
RESULT_WIDTH, 2*DATA_WIDTH, result width; result = acc[ACC_WIDTH-1 -: RESULT_WIDTH]
CNT_WIDTH, 8, term-counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  term vector valid
in_ready  out  1  block can accept a term
in_last  in  1  term is last of dot product
act_in  in  [VEC_LENGTH][DATA_WIDTH]  signed activations
w_idx  in  [VEC_LENGTH][SHIFT_WIDTH]  shift amount per lane
w_en  in  [VEC_LENGTH]  lane enable; 0 contributes 0
is_neg  in  [VEC_LENGTH]  negate lane term
load_accum  in  1  seed accumulator with result_prev (first term only)
is_pooling  in  1  max-pool mode (first term only)
result_prev  in  RESULT_WIDTH  signed seed / pooling operand (first term only)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  RESULT_WIDTH  signed result
term_cnt  out  CNT_WIDTH  number of terms in the emitted dot product, saturating

Behaviour:
- Reset (clk, reset: synchronous, active-high): out_valid=0, result=0, term_cnt=0. Pipeline valid bits, accumulator and first-term flag cleared. Reset mid-dot-product discards the partial sum; the next accepted term is a first term.
- Stall: adv = !(out_valid && !out_ready). in_ready = adv (combinational from out_ready). When adv=0, every pipeline register holds.
- Lane: widen act to DATA_WIDTH+1 before negating, so -(-128) = +128 exactly; shift left by w_idx; zero if !w_en. Lane width is DATA_WIDTH+2^SHIFT_WIDTH. Tree adds 1 bit per level, with exact sign extension.
- S1 (accept edge, in_valid && in_ready): psum_reg <= tree sum; v1<=1; l1<=in_last; f1<=first.
  - When f1 is set, also latch load_accum, is_pooling and result_prev.
  - first is set after reset and after any accepted last term.
  - If no term is accepted and adv=1, v1<=0.
- S2 (edge when v1 && adv):
  - acc_next = (f1 ? base : acc) + sext(psum_reg).
  - base = load_accum_l ? {result_prev_l, (ACC_WIDTH-RESULT_WIDTH) zeros} : 0.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
  - cnt_next = f1 ? 1 : sat(cnt+1).
- Output (same edge, if l1): result <= pooling_l ? signed_max(acc_next[top], result_prev_l) : acc_next[top], where [top] = [ACC_WIDTH-1 -: RESULT_WIDTH]. Also term_cnt <= cnt_next, out_valid <= 1.
- Latency: out_valid rises exactly 2 cycles after the accepting edge of the last term, absent stall.
- Single-term dot product (first and last together) is legal.
- out_valid && out_ready with no new last in S2: out_valid <= 0. A new last in S2 on the same edge reloads the output register.
- Throughput: 1 term/cycle. Back-to-back dot products need no bubble.
- in_valid=0 gaps inside a dot product are allowed; the accumulator holds.

Decomposition:
- pragmatic_pkg:
  - function lane_w(DATA_WIDTH, SHIFT_WIDTH)
  - function tree_w(lane_w, VEC_LENGTH)
  - typedef for pooling/load control bundle
- Sub-module pragmatic_lane: sign + shift + enable, combinational.
- Adder tree: generate loop over $clog2(VEC_LENGTH) levels in the top module.

Test Plan:
1. Defaults; one term, all 16 lanes act=16, w_idx=0, w_en=1, in_last, load_accum=0 -> acc=256, result=0x0001, term_cnt=1, out_valid 2 cycles after accept.
2. Three back-to-back terms, all lanes act=127, w_idx=7,4,0, last on third -> acc=294640, result=1150, term_cnt=3. Then an immediate next dot product is correct with no bubble.
3. Lane 0 only: act=-128, is_neg=1, w_idx=7, other w_en=0 -> +16384, result=0x0040 (no wrap).
4. Test 1 with load_accum=1, result_prev=0x0100 -> acc=0x010100, result=0x0101.
5. Test 4 stimulus with load_accum=0, is_pooling=1:
   - result_prev=0x0200 -> result=0x0200.
   - result_prev=0xFFFB -> result=0x0001 (signed compare).
6. Backpressure: hold out_ready=0 while out_valid=1 and drive the next dot product -> in_ready=0 and result stable. Release -> second result correct. Assert reset mid-product -> out_valid=0, term_cnt=0, next product unaffected.
